// File: rtl/routing_seq_ctrl_if.sv
// Command, data-handshake and routing-array control bundle for routing_seq_ctrl.
// The slave modport is the sequencer's view; the master modport is the command source's view.
interface routing_seq_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             cmd_vld;
  logic             cmd_rdy;
  logic [2:0]       cmd_mode;
  logic [1:0]       cmd_stride;
  logic [CNT_W-1:0] cmd_beats;
  logic             abort;
  logic             din_vld;
  logic             din_rdy;
  logic [2:0]       calculation_mode;
  logic [1:0]       stride;
  logic             bitmask_reload;
  logic             bitmask_shift;
  logic             routing_in_vld;
  logic             sparse_start;
  logic             weight_uncompress_done;
  logic             uncompress_update;
  logic [1:0]       shift_phase;
  logic             busy;
  logic             done;
  logic             err;

  modport slave (
    input  cmd_vld, cmd_mode, cmd_stride, cmd_beats, abort, din_vld,
           weight_uncompress_done,
    output cmd_rdy, din_rdy, calculation_mode, stride, bitmask_reload,
           bitmask_shift, routing_in_vld, sparse_start, uncompress_update,
           shift_phase, busy, done, err
  );

  modport master (
    output cmd_vld, cmd_mode, cmd_stride, cmd_beats, abort, din_vld,
           weight_uncompress_done,
    input  cmd_rdy, din_rdy, calculation_mode, stride, bitmask_reload,
           bitmask_shift, routing_in_vld, sparse_start, uncompress_update,
           shift_phase, busy, done, err
  );
endinterface

// File: rtl/routing_seq_ctrl.sv
// Sequencer that loads a routing command, optionally runs the sparse decompressor,
// then streams data beats into the routing array while rotating the bitmask.
module routing_seq_ctrl #(
  parameter int CNT_W    = 8,
  parameter int WDOG_MAX = 255
) (
  input  logic              clk,
  input  logic              rstn,
  routing_seq_ctrl_if.slave bus
);

  localparam int WDOG_W = $clog2(WDOG_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SP_START,
    ST_SP_WAIT,
    ST_SP_UPD,
    ST_STREAM,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [1:0]       stride_q, stride_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [1:0]       phase_q, phase_d;
  logic             err_q, err_d;

  logic mode_ok;
  logic is_sparse;
  logic act;

  assign mode_ok   = (bus.cmd_mode == 3'b001) || (bus.cmd_mode == 3'b010) ||
                     (bus.cmd_mode == 3'b101);
  assign is_sparse = (mode_q == 3'b001);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      mode_q   <= '0;
      stride_q <= '0;
      cnt_q    <= '0;
      wdog_q   <= '0;
      phase_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      stride_q <= stride_d;
      cnt_q    <= cnt_d;
      wdog_q   <= wdog_d;
      phase_q  <= phase_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    stride_d = stride_q;
    cnt_d    = cnt_q;
    wdog_d   = wdog_q;
    phase_d  = phase_q;
    err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_vld) begin
          if (mode_ok) begin
            mode_d   = bus.cmd_mode;
            stride_d = bus.cmd_stride;
            cnt_d    = bus.cmd_beats;
            state_d  = (bus.cmd_beats == '0) ? ST_DONE : ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        phase_d = 2'd0;
        wdog_d  = '0;
        state_d = is_sparse ? ST_SP_START : ST_STREAM;
      end
      ST_SP_START: state_d = ST_SP_WAIT;
      ST_SP_WAIT: begin
        if (bus.weight_uncompress_done) begin
          state_d = ST_SP_UPD;
        end else if (wdog_q == WDOG_W'(WDOG_MAX - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_SP_UPD: state_d = ST_STREAM;
      ST_STREAM: begin
        if (bus.din_vld) begin
          cnt_d = cnt_q - 1'b1;
          // Stride 00 walks all four rotation slots; wider strides only alternate two.
          if (!is_sparse) begin
            phase_d = (stride_q == 2'b00) ? phase_q + 2'd1 : {1'b0, ~phase_q[0]};
          end
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = cnt_q;
      wdog_d  = wdog_q;
      phase_d = phase_q;
      err_d   = 1'b0;
    end
  end

  // An abort cycle keeps busy up but silences every strobe, including din_rdy.
  assign act = rstn && !(bus.abort && (state_q != ST_IDLE));

  always_comb begin
    bus.cmd_rdy           = (state_q == ST_IDLE);
    bus.busy              = rstn && (state_q != ST_IDLE);
    bus.din_rdy           = act && (state_q == ST_STREAM);
    bus.routing_in_vld    = act && (state_q == ST_STREAM) && bus.din_vld;
    bus.bitmask_shift     = act && (state_q == ST_STREAM) && bus.din_vld && !is_sparse;
    bus.bitmask_reload    = act && (state_q == ST_LOAD);
    bus.sparse_start      = act && (state_q == ST_SP_START);
    bus.uncompress_update = act && (state_q == ST_SP_UPD);
    bus.done              = act && (state_q == ST_DONE);
    bus.err               = rstn && err_q;
    bus.calculation_mode  = mode_q;
    bus.stride            = stride_q;
    bus.shift_phase       = phase_q;
  end

endmodule

// File: tb/tb_routing_seq_ctrl.sv
// Scoreboard bench for routing_seq_ctrl: directed commands push expected strobe
// records (cycle, strobe vector, phase) that a negedge monitor pops and compares.
module tb_routing_seq_ctrl;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  routing_seq_ctrl_if #(.CNT_W(8)) bus ();

  routing_seq_ctrl #(.CNT_W(8), .WDOG_MAX(255)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Strobe vector order: reload, shift, routing_in_vld, sparse_start, update, done, err
  localparam logic [6:0] S_RELOAD = 7'b1000000;
  localparam logic [6:0] S_SV     = 7'b0110000;
  localparam logic [6:0] S_VLD    = 7'b0010000;
  localparam logic [6:0] S_START  = 7'b0001000;
  localparam logic [6:0] S_UPD    = 7'b0000100;
  localparam logic [6:0] S_DONE   = 7'b0000010;
  localparam logic [6:0] S_ERR    = 7'b0000001;

  typedef struct packed {
    logic [31:0] cyc;
    logic [6:0]  strb;
    logic        chk_ph;
    logic [1:0]  ph;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] obsStrb();
    return {bus.bitmask_reload, bus.bitmask_shift, bus.routing_in_vld,
            bus.sparse_start, bus.uncompress_update, bus.done, bus.err};
  endfunction

  // Monitor: every cycle with any strobe active must match the oldest expected record.
  always @(negedge clk) begin : monitor
    logic [6:0] s;
    exp_t       e;
    s = obsStrb();
    if (s != 7'd0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_strobe cyc=%0d got=%b expected=none", cyc, s);
      end else begin
        e = exp_q.pop_front();
        if ((e.cyc != 32'(cyc)) || (e.strb != s) ||
            (e.chk_ph && (e.ph != bus.shift_phase))) begin
          errors++;
          $display("[TB] FAIL strobe cyc=%0d strb=%b ph=%0d expected cyc=%0d strb=%b ph=%0d",
                   cyc, s, bus.shift_phase, e.cyc, e.strb, e.ph);
        end
      end
    end
  end

  initial begin : timeout
    #100000;
    $display("[TB] FAIL timeout got=running expected=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [6:0] s, input logic cp, input logic [1:0] p);
    exp_t e;
    e.cyc    = 32'(c);
    e.strb   = s;
    e.chk_ph = cp;
    e.ph     = p;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s got=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Presents one command for a single cycle; t returns the acceptance cycle T.
  task automatic applyStimulus(input logic [2:0] m, input logic [1:0] s,
                               input logic [7:0] b, output int t);
    checkOutput("cmd_rdy_idle", int'(bus.cmd_rdy), 1);
    bus.cmd_vld    = 1'b1;
    bus.cmd_mode   = m;
    bus.cmd_stride = s;
    bus.cmd_beats  = b;
    t = cyc;
    tick();
    bus.cmd_vld = 1'b0;
  endtask

  task automatic driveCycles(input logic [15:0] vld, input logic [15:0] wd,
                             input logic [15:0] ab, input int n);
    for (int i = 0; i < n; i++) begin
      bus.din_vld                = vld[i];
      bus.weight_uncompress_done = wd[i];
      bus.abort                  = ab[i];
      tick();
    end
    bus.din_vld                = 1'b0;
    bus.weight_uncompress_done = 1'b0;
    bus.abort                  = 1'b0;
  endtask

  initial begin : stimulus
    int t;
    bus.cmd_vld                = 1'b0;
    bus.cmd_mode               = 3'd0;
    bus.cmd_stride             = 2'd0;
    bus.cmd_beats              = 8'd0;
    bus.abort                  = 1'b0;
    bus.din_vld                = 1'b0;
    bus.weight_uncompress_done = 1'b0;

    // Power-on reset
    repeat (3) tick();
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_strobes", int'(obsStrb()), 0);
    checkOutput("rst_din_rdy", int'(bus.din_rdy), 0);
    rstn = 1'b1;
    tick();
    checkOutput("post_rst_cmd_rdy", int'(bus.cmd_rdy), 1);
    checkOutput("post_rst_busy", int'(bus.busy), 0);
    checkOutput("post_rst_mode", int'(bus.calculation_mode), 0);
    checkOutput("post_rst_phase", int'(bus.shift_phase), 0);

    // dwconv: mode 010, stride 00, 6 beats, din_vld always high
    applyStimulus(3'b010, 2'b00, 8'd6, t);
    push(t + 1, S_RELOAD, 1'b0, 2'd0);
    for (int k = 0; k < 6; k++) push(t + 2 + k, S_SV, 1'b1, 2'(k % 4));
    push(t + 8, S_DONE, 1'b1, 2'd2);
    checkOutput("t1_busy_load", int'(bus.busy), 1);
    driveCycles(16'hFFFF, 16'h0000, 16'h0000, 8);
    checkOutput("t1_busy_after", int'(bus.busy), 0);
    checkOutput("t1_mode", int'(bus.calculation_mode), 2);

    // stride 01 with gaps: mode 101, 3 beats on alternate cycles
    applyStimulus(3'b101, 2'b01, 8'd3, t);
    push(t + 1, S_RELOAD, 1'b0, 2'd0);
    push(t + 2, S_SV, 1'b1, 2'd0);
    push(t + 4, S_SV, 1'b1, 2'd1);
    push(t + 6, S_SV, 1'b1, 2'd0);
    push(t + 7, S_DONE, 1'b1, 2'd1);
    driveCycles(16'h0002, 16'h0000, 16'h0000, 2);
    checkOutput("t2_gap1_din_rdy", int'(bus.din_rdy), 1);
    driveCycles(16'h0002, 16'h0000, 16'h0000, 2);
    checkOutput("t2_gap2_din_rdy", int'(bus.din_rdy), 1);
    driveCycles(16'h0002, 16'h0000, 16'h0000, 2);
    tick();
    checkOutput("t2_stride", int'(bus.stride), 1);
    checkOutput("t2_mode", int'(bus.calculation_mode), 5);

    // sparse: done 5 cycles after sparse_start, stray done in LOAD, din_vld early
    applyStimulus(3'b001, 2'b00, 8'd2, t);
    push(t + 1, S_RELOAD, 1'b0, 2'd0);
    push(t + 2, S_START, 1'b0, 2'd0);
    push(t + 8, S_UPD, 1'b0, 2'd0);
    push(t + 9, S_VLD, 1'b1, 2'd0);
    push(t + 10, S_VLD, 1'b1, 2'd0);
    push(t + 11, S_DONE, 1'b0, 2'd0);
    driveCycles(16'h03FC, 16'h0041, 16'h0000, 11);
    checkOutput("t3_busy_after", int'(bus.busy), 0);

    // watchdog: decompressor never finishes
    applyStimulus(3'b001, 2'b00, 8'd4, t);
    push(t + 1, S_RELOAD, 1'b0, 2'd0);
    push(t + 2, S_START, 1'b0, 2'd0);
    push(t + 258, S_ERR, 1'b0, 2'd0);
    repeat (256) tick();
    checkOutput("t4_busy_last_wait", int'(bus.busy), 1);
    tick();
    checkOutput("t4_busy_after_err", int'(bus.busy), 0);
    tick();

    // illegal mode: err, no busy, previous mode kept
    applyStimulus(3'b011, 2'b11, 8'd5, t);
    push(t + 1, S_ERR, 1'b0, 2'd0);
    checkOutput("t5_busy", int'(bus.busy), 0);
    checkOutput("t5_mode_kept", int'(bus.calculation_mode), 1);

    // zero beats with abort held in IDLE: accepted anyway, done at T+1, no reload
    bus.abort = 1'b1;
    applyStimulus(3'b010, 2'b10, 8'd0, t);
    bus.abort = 1'b0;
    push(t + 1, S_DONE, 1'b0, 2'd0);
    tick();
    checkOutput("t5_zero_mode", int'(bus.calculation_mode), 2);
    checkOutput("t5_zero_stride", int'(bus.stride), 2);

    // abort at the third STREAM beat
    applyStimulus(3'b010, 2'b00, 8'd6, t);
    push(t + 1, S_RELOAD, 1'b0, 2'd0);
    push(t + 2, S_SV, 1'b1, 2'd0);
    push(t + 3, S_SV, 1'b1, 2'd1);
    driveCycles(16'h000F, 16'h0000, 16'h0008, 4);
    checkOutput("t6_busy_after_abort", int'(bus.busy), 0);
    checkOutput("t6_phase_after_abort", int'(bus.shift_phase), 2);
    repeat (3) tick();

    // reset while waiting on the decompressor
    applyStimulus(3'b001, 2'b01, 8'd2, t);
    push(t + 1, S_RELOAD, 1'b0, 2'd0);
    push(t + 2, S_START, 1'b0, 2'd0);
    driveCycles(16'h0000, 16'h0000, 16'h0000, 3);
    rstn = 1'b0;
    bus.weight_uncompress_done = 1'b1;
    #1;
    checkOutput("t7_rst_busy", int'(bus.busy), 0);
    checkOutput("t7_rst_strobes", int'(obsStrb()), 0);
    tick();
    checkOutput("t7_rst_busy2", int'(bus.busy), 0);
    rstn = 1'b1;
    bus.weight_uncompress_done = 1'b0;
    tick();
    checkOutput("t7_cmd_rdy", int'(bus.cmd_rdy), 1);
    checkOutput("t7_busy", int'(bus.busy), 0);
    checkOutput("t7_mode_cleared", int'(bus.calculation_mode), 0);
    checkOutput("t7_stride_cleared", int'(bus.stride), 0);
    repeat (4) tick();

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
